instr_fetch: RTL and testbench

//  Fetch stage directly downstream of the program counter. Each cycle it decides

---
 rtl/instr_fetch.sv | 102 ++++++++++
 tb/tb_instr_fetch.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch.sv
// Fetch stage: gates PC advance, reads instruction memory and buffers the
// returned words in a small FIFO with a valid/ready handshake to decode.
// Ports:
//   clk, reset (async, active-low)
//   prog_ctr   -> imem_addr, imem_rd_en (read strobe, data one cycle later)
//   next_flag  -> PC advance/load enable; redirect <- jump taken this cycle
//   imem_rdata <- instruction memory read data
//   instr, instr_pc, instr_valid -> decode; instr_ready <- decode accepts head
module instr_fetch #(
    parameter int D     = 12,
    parameter int W     = 9,
    parameter int DEPTH = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [D-1:0] prog_ctr,
    output logic         next_flag,
    input  logic         redirect,
    output logic [D-1:0] imem_addr,
    output logic         imem_rd_en,
    input  logic [W-1:0] imem_rdata,
    output logic [W-1:0] instr,
    output logic [D-1:0] instr_pc,
    output logic         instr_valid,
    input  logic         instr_ready
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 2;

    logic [AW:0]   count_q, count_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic          inflight_q;
    logic          kill_q, kill_d;
    logic [D-1:0]  resp_pc_q;
    logic [W-1:0]  word_q [DEPTH];
    logic [D-1:0]  addr_q [DEPTH];

    logic pop;
    logic push;
    logic issue;

    assign instr_valid = (count_q != '0);
    assign instr       = word_q[rd_ptr_q];
    assign instr_pc    = addr_q[rd_ptr_q];
    assign imem_addr   = prog_ctr;
    assign imem_rd_en  = issue;
    assign next_flag   = issue | redirect;

    always_comb begin
        pop  = instr_valid & instr_ready & ~redirect;
        push = inflight_q & ~kill_q & ~redirect;
        // Credit check: buffered + in-flight words must leave room, counting
        // the slot freed by a pop this cycle. Rearranged to stay unsigned.
        issue = reset & ~redirect &
                ((CW'(count_q) + CW'(inflight_q)) < (CW'(DEPTH) + CW'(pop)));
    end

    always_comb begin
        count_d  = count_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        kill_d   = redirect & inflight_q;
        if (redirect) begin
            count_d  = '0;
            rd_ptr_d = '0;
            wr_ptr_d = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            count_d = count_q + (AW+1)'(push) - (AW+1)'(pop);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q    <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            inflight_q <= 1'b0;
            kill_q     <= 1'b0;
            resp_pc_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                word_q[i] <= '0;
                addr_q[i] <= '0;
            end
        end else begin
            count_q    <= count_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            inflight_q <= issue;
            kill_q     <= kill_d;
            if (issue) resp_pc_q <= prog_ctr;
            if (push) begin
                word_q[wr_ptr_q] <= imem_rdata;
                addr_q[wr_ptr_q] <= resp_pc_q;
            end
        end
    end

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: PC and ROM environment models, a scoreboard of
// issued fetches, and scenario tasks with explicit timing checks.
module tb_instr_fetch;

    logic        clk = 1'b0;
    logic        reset;
    logic [11:0] pc = '0;
    logic [11:0] target = '0;
    logic        next_flag;
    logic        redirect;
    logic [11:0] imem_addr;
    logic        imem_rd_en;
    logic [8:0]  rdata = '0;
    logic [8:0]  instr;
    logic [11:0] instr_pc;
    logic        instr_valid;
    logic        ready;

    int checks = 0;
    int errors = 0;

    logic [20:0] sb_q [$];

    instr_fetch #(.D(12), .W(9), .DEPTH(2)) dut (
        .clk        (clk),
        .reset      (reset),
        .prog_ctr   (pc),
        .next_flag  (next_flag),
        .redirect   (redirect),
        .imem_addr  (imem_addr),
        .imem_rd_en (imem_rd_en),
        .imem_rdata (rdata),
        .instr      (instr),
        .instr_pc   (instr_pc),
        .instr_valid(instr_valid),
        .instr_ready(ready)
    );

    always #5 clk = ~clk;

    function automatic logic [8:0] rom(input logic [11:0] a);
        return a[8:0] + 9'h010;
    endfunction

    // PC stage and synchronous instruction memory
    always @(posedge clk) begin
        if (next_flag) pc <= redirect ? target : pc + 12'd1;
        if (imem_rd_en) rdata <= rom(imem_addr);
    end

    // Scoreboard: push on issue, pop/compare on accepted handshake
    always @(negedge clk) begin
        logic [20:0] exp;
        if (!reset) begin
            sb_q.delete();
        end else begin
            checks++;
            if (next_flag !== (imem_rd_en | redirect)) begin
                errors++;
                $display("FAIL next_flag: got %b want %b", next_flag,
                         imem_rd_en | redirect);
            end
            if (redirect) begin
                checks++;
                if (imem_rd_en !== 1'b0) begin
                    errors++;
                    $display("FAIL rd_en_in_redirect: got %b want 0", imem_rd_en);
                end
                sb_q.delete();
            end else if (instr_valid && ready) begin
                checks++;
                if (sb_q.size() == 0) begin
                    errors++;
                    $display("FAIL sb_unexpected: got %h/%h want none",
                             instr, instr_pc);
                end else begin
                    exp = sb_q.pop_front();
                    if ({instr, instr_pc} !== exp) begin
                        errors++;
                        $display("FAIL sb_order: got %h/%h want %h/%h",
                                 instr, instr_pc, exp[20:12], exp[11:0]);
                    end
                end
            end
            if (imem_rd_en) begin
                checks++;
                if (imem_addr !== pc) begin
                    errors++;
                    $display("FAIL imem_addr: got %h want %h", imem_addr, pc);
                end
                sb_q.push_back({rom(pc), pc});
            end
        end
    end

    task automatic test_reset();
        reset = 1'b0;
        redirect = 1'b0;
        ready = 1'b0;
        repeat (5) begin
            @(negedge clk);
            checks++;
            if ({instr_valid, next_flag, imem_rd_en, instr, instr_pc} !== '0) begin
                errors++;
                $display("FAIL reset_outs: got v%b nf%b rd%b i%h pc%h want 0",
                         instr_valid, next_flag, imem_rd_en, instr, instr_pc);
            end
        end
        @(posedge clk);
        #1 reset = 1'b1;
        ready = 1'b1;
        #1;
        checks++;
        if ({imem_rd_en, next_flag, imem_addr} !== {1'b1, 1'b1, 12'h000}) begin
            errors++;
            $display("FAIL first_issue: got rd%b nf%b a%h want rd1 nf1 a000",
                     imem_rd_en, next_flag, imem_addr);
        end
    endtask

    task automatic test_stream();
        for (int k = 0; k < 12; k++) begin
            if (k > 0) @(negedge clk);
            else @(negedge clk);
            checks++;
            if (instr_valid !== (k >= 2)) begin
                errors++;
                $display("FAIL stream_valid: cyc %0d got %b want %b",
                         k, instr_valid, k >= 2);
            end
            if (k >= 2) begin
                checks++;
                if ({instr, instr_pc} !== {9'(9'h010 + 9'(k - 2)), 12'(k - 2)}) begin
                    errors++;
                    $display("FAIL stream_data: cyc %0d got %h/%h want %h/%h",
                             k, instr, instr_pc, 9'h010 + 9'(k - 2), 12'(k - 2));
                end
            end
        end
    endtask

    task automatic test_stall();
        logic [11:0] frozen;
        @(posedge clk);
        #1 ready = 1'b0;
        frozen = pc;
        repeat (6) begin
            @(negedge clk);
            checks++;
            if (next_flag !== 1'b0 || pc !== frozen) begin
                errors++;
                $display("FAIL stall_hold: got nf%b pc%h want nf0 pc%h",
                         next_flag, pc, frozen);
            end
        end
        checks++;
        if (instr_valid !== 1'b1) begin
            errors++;
            $display("FAIL stall_full: got valid %b want 1", instr_valid);
        end
        @(posedge clk);
        #1 ready = 1'b1;
        repeat (6) begin
            @(negedge clk);
            checks++;
            if (instr_valid !== 1'b1 || next_flag !== 1'b1) begin
                errors++;
                $display("FAIL resume: got v%b nf%b want v1 nf1",
                         instr_valid, next_flag);
            end
        end
    endtask

    task automatic check_target(input string nm, input logic [11:0] t);
        @(negedge clk);
        checks++;
        if (instr_valid !== 1'b0) begin
            errors++;
            $display("FAIL %s_flush1: got valid %b want 0", nm, instr_valid);
        end
        @(negedge clk);
        checks++;
        if (instr_valid !== 1'b0) begin
            errors++;
            $display("FAIL %s_flush2: got valid %b want 0", nm, instr_valid);
        end
        @(negedge clk);
        checks++;
        if ({instr_valid, instr, instr_pc} !== {1'b1, rom(t), t}) begin
            errors++;
            $display("FAIL %s_target: got v%b %h/%h want v1 %h/%h",
                     nm, instr_valid, instr, instr_pc, rom(t), t);
        end
    endtask

    task automatic test_redirect();
        @(posedge clk);
        #1 ready = 1'b0;
        redirect = 1'b1;
        target = 12'h040;
        @(negedge clk);
        checks++;
        if (next_flag !== 1'b1 || instr_valid !== 1'b1) begin
            errors++;
            $display("FAIL redir_cycle: got nf%b v%b want nf1 v1",
                     next_flag, instr_valid);
        end
        @(posedge clk);
        #1 redirect = 1'b0;
        ready = 1'b1;
        check_target("redir", 12'h040);
    endtask

    task automatic test_redirect_pop();
        repeat (3) @(negedge clk);
        @(posedge clk);
        #1 redirect = 1'b1;
        target = 12'h080;
        @(negedge clk);
        checks++;
        if ((instr_valid & ready) !== 1'b1) begin
            errors++;
            $display("FAIL redir_pop_pre: got v%b want 1", instr_valid);
        end
        @(posedge clk);
        #1 redirect = 1'b0;
        check_target("redir_pop", 12'h080);
    endtask

    task automatic test_back_to_back();
        repeat (2) @(negedge clk);
        @(posedge clk);
        #1 redirect = 1'b1;
        target = 12'h100;
        @(negedge clk);
        checks++;
        if (next_flag !== 1'b1) begin
            errors++;
            $display("FAIL b2b_first: got nf%b want 1", next_flag);
        end
        @(posedge clk);
        #1 target = 12'h200;
        @(negedge clk);
        checks++;
        if (next_flag !== 1'b1 || instr_valid !== 1'b0) begin
            errors++;
            $display("FAIL b2b_second: got nf%b v%b want nf1 v0",
                     next_flag, instr_valid);
        end
        @(posedge clk);
        #1 redirect = 1'b0;
        check_target("b2b", 12'h200);
    endtask

    task automatic test_reset_mid();
        logic [11:0] start;
        repeat (4) @(negedge clk);
        @(posedge clk);
        #3 reset = 1'b0;
        #1;
        checks++;
        if ({instr_valid, next_flag, imem_rd_en, instr, instr_pc} !== '0) begin
            errors++;
            $display("FAIL mid_reset_async: got v%b nf%b rd%b i%h pc%h want 0",
                     instr_valid, next_flag, imem_rd_en, instr, instr_pc);
        end
        @(negedge clk);
        checks++;
        if ({instr_valid, next_flag, imem_rd_en} !== 3'b000) begin
            errors++;
            $display("FAIL mid_reset_hold: got v%b nf%b rd%b want 0",
                     instr_valid, next_flag, imem_rd_en);
        end
        @(posedge clk);
        #1 reset = 1'b1;
        start = pc;
        #1;
        checks++;
        if (imem_rd_en !== 1'b1 || imem_addr !== start) begin
            errors++;
            $display("FAIL mid_restart: got rd%b a%h want rd1 a%h",
                     imem_rd_en, imem_addr, start);
        end
        @(negedge clk);
        checks++;
        if (instr_valid !== 1'b0) begin
            errors++;
            $display("FAIL mid_empty0: got v%b want 0", instr_valid);
        end
        @(negedge clk);
        checks++;
        if (instr_valid !== 1'b0) begin
            errors++;
            $display("FAIL mid_empty1: got v%b want 0", instr_valid);
        end
        @(negedge clk);
        checks++;
        if ({instr_valid, instr, instr_pc} !== {1'b1, rom(start), start}) begin
            errors++;
            $display("FAIL mid_first: got v%b %h/%h want v1 %h/%h",
                     instr_valid, instr, instr_pc, rom(start), start);
        end
        repeat (4) @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_stream();
        test_stall();
        test_redirect();
        test_redirect_pop();
        test_back_to_back();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
